// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter with a one-hot registered grant.
// The grant is held until the owner releases it or the watchdog expires.
module or_n_to_1 #(
  parameter int N = 8
) (
  input  logic [N-1:0] in_i,
  output logic         out_o
);

  assign out_o = |in_i;

endmodule

module rr_req_arbiter #(
  parameter int NUM_INPUTS     = 8,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IDX_W         = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] req,
  input  logic                  done,
  output logic [NUM_INPUTS-1:0] gnt,
  output logic                  gnt_valid,
  output logic [IDX_W-1:0]      gnt_idx,
  output logic                  any_req,
  output logic                  timeout_err
);

  localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t                  state_q;
  logic [NUM_INPUTS-1:0]   gnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        ptr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    valid_q;
  logic                    terr_q;

  logic [IDX_W:0]          cand;
  logic [IDX_W-1:0]        sel_idx;
  logic [IDX_W-1:0]        idx_inc;
  logic                    rel_done;
  logic                    rel_drop;
  logic                    rel_to;

  or_n_to_1 #(
    .N (NUM_INPUTS)
  ) u_or (
    .in_i  (req),
    .out_o (any_req)
  );

  // Scan downwards so the lowest offset from ptr wins.
  always_comb begin
    cand    = '0;
    sel_idx = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_INPUTS)) begin
        cand = cand - (IDX_W+1)'(NUM_INPUTS);
      end
      if (req[cand[IDX_W-1:0]]) begin
        sel_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign idx_inc  = (idx_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : idx_q + 1'b1;
  assign rel_done = done;
  assign rel_drop = ~req[idx_q];
  assign rel_to   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      terr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q   <= {{(NUM_INPUTS-1){1'b0}}, 1'b1} << sel_idx;
            idx_q   <= sel_idx;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (rel_done || rel_drop || rel_to) begin
            gnt_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= idx_inc;
            state_q <= IDLE;
            // A watchdog hit that coincides with a normal release is not an error.
            terr_q  <= rel_to && !rel_done && !rel_drop;
          end else if (TIMEOUT_CYCLES != 0 && cnt_q != CNT_W'(TO_LAST)) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign gnt_valid   = valid_q;
  assign gnt_idx     = idx_q;
  assign timeout_err = terr_q;

`ifndef SYNTHESIS
  a_onehot: assert property (@(posedge clk) $onehot0(gnt));
  a_valid:  assert property (@(posedge clk) gnt_valid == |gnt);
  a_owner:  assert property (@(posedge clk) !gnt_valid || gnt[gnt_idx]);
`endif

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Bench for rr_req_arbiter: directed vectors, watchdog sequences,
// a 5-input instance and random traffic against a reference model.
module tb_rr_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req8;
  logic       done8;
  logic [7:0] gnt8;
  logic       v8;
  logic [2:0] idx8;
  logic       any8;
  logic       terr8;

  logic [4:0] req5;
  logic       done5;
  logic [4:0] gnt5;
  logic       v5;
  logic [2:0] idx5;
  logic       any5;
  logic       terr5;

  int n_chk;
  int n_pass;

  rr_req_arbiter #(
    .NUM_INPUTS     (8),
    .TIMEOUT_CYCLES (16)
  ) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req8),
    .done        (done8),
    .gnt         (gnt8),
    .gnt_valid   (v8),
    .gnt_idx     (idx8),
    .any_req     (any8),
    .timeout_err (terr8)
  );

  rr_req_arbiter #(
    .NUM_INPUTS     (5),
    .TIMEOUT_CYCLES (16)
  ) dut5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req5),
    .done        (done5),
    .gnt         (gnt5),
    .gnt_valid   (v5),
    .gnt_idx     (idx5),
    .any_req     (any5),
    .timeout_err (terr5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic       rst;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       terr;
  } vec_t;

  localparam int NV = 37;
  vec_t tbl [NV];

  // reference model state
  int m_owner;
  int m_ptr;
  int m_held;
  int m_idx;
  bit m_terr;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_step(input logic [7:0] r, input logic d,
                            input logic rn);
    bit to_hit;
    if (!rn) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_idx   = 0;
      m_terr  = 0;
    end else if (m_owner < 0) begin
      m_terr = 0;
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (m_ptr + k) % 8;
        if (r[c]) begin
          m_owner = c;
          m_idx   = c;
          m_held  = 1;
          break;
        end
      end
    end else begin
      to_hit = (m_held == 16);
      if (d || !r[m_owner] || to_hit) begin
        m_terr  = to_hit && !d && r[m_owner];
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_terr = 0;
        m_held++;
      end
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] eg,
                      input logic et);
    check({tag, " gnt"}, gnt8, eg);
    check({tag, " valid"}, v8, |eg);
    check({tag, " terr"}, terr8, et);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    req8   = '0;
    done8  = 1'b0;
    req5   = '0;
    done5  = 1'b0;

    tbl[0]  = '{8'hFF, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[1]  = '{8'hFF, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[2]  = '{8'hFF, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[3]  = '{8'hFF, 1'b0, 1'b1, 8'h01, 3'd0, 1'b0};
    tbl[4]  = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0};
    tbl[5]  = '{8'hFF, 1'b0, 1'b1, 8'h02, 3'd1, 1'b0};
    tbl[6]  = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd1, 1'b0};
    tbl[7]  = '{8'hFF, 1'b0, 1'b1, 8'h04, 3'd2, 1'b0};
    tbl[8]  = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd2, 1'b0};
    tbl[9]  = '{8'hFF, 1'b0, 1'b1, 8'h08, 3'd3, 1'b0};
    tbl[10] = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd3, 1'b0};
    tbl[11] = '{8'hFF, 1'b0, 1'b1, 8'h10, 3'd4, 1'b0};
    tbl[12] = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd4, 1'b0};
    tbl[13] = '{8'hFF, 1'b0, 1'b1, 8'h20, 3'd5, 1'b0};
    tbl[14] = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd5, 1'b0};
    tbl[15] = '{8'hFF, 1'b0, 1'b1, 8'h40, 3'd6, 1'b0};
    tbl[16] = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd6, 1'b0};
    tbl[17] = '{8'hFF, 1'b0, 1'b1, 8'h80, 3'd7, 1'b0};
    tbl[18] = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd7, 1'b0};
    tbl[19] = '{8'hFF, 1'b0, 1'b1, 8'h01, 3'd0, 1'b0};
    tbl[20] = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0};
    tbl[21] = '{8'h40, 1'b0, 1'b1, 8'h40, 3'd6, 1'b0};
    tbl[22] = '{8'h40, 1'b1, 1'b1, 8'h00, 3'd6, 1'b0};
    tbl[23] = '{8'h21, 1'b0, 1'b1, 8'h01, 3'd0, 1'b0};
    tbl[24] = '{8'h21, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0};
    tbl[25] = '{8'h21, 1'b0, 1'b1, 8'h20, 3'd5, 1'b0};
    tbl[26] = '{8'h21, 1'b1, 1'b1, 8'h00, 3'd5, 1'b0};
    tbl[27] = '{8'h08, 1'b0, 1'b1, 8'h08, 3'd3, 1'b0};
    tbl[28] = '{8'hFF, 1'b0, 1'b1, 8'h08, 3'd3, 1'b0};
    tbl[29] = '{8'hFF, 1'b0, 1'b1, 8'h08, 3'd3, 1'b0};
    tbl[30] = '{8'hFF, 1'b0, 1'b1, 8'h08, 3'd3, 1'b0};
    tbl[31] = '{8'hFF, 1'b0, 1'b1, 8'h08, 3'd3, 1'b0};
    tbl[32] = '{8'hF7, 1'b0, 1'b1, 8'h00, 3'd3, 1'b0};
    tbl[33] = '{8'h10, 1'b0, 1'b1, 8'h10, 3'd4, 1'b0};
    tbl[34] = '{8'h10, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    tbl[35] = '{8'h30, 1'b0, 1'b1, 8'h10, 3'd4, 1'b0};
    tbl[36] = '{8'h30, 1'b1, 1'b1, 8'h00, 3'd4, 1'b0};

    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      req8  = tbl[i].req;
      done8 = tbl[i].done;
      rst_n = tbl[i].rst;
      step();
      chk8($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].terr);
      check($sformatf("vec%0d idx", i), idx8, tbl[i].idx);
      check($sformatf("vec%0d any", i), any8, |tbl[i].req);
    end

    // watchdog: 16 held cycles, forced release, re-grant
    req8  = 8'h04;
    done8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk8($sformatf("wd_hold%0d", i), 8'h04, 1'b0);
    end
    step();
    chk8("wd_expire", 8'h00, 1'b1);
    step();
    chk8("wd_regrant", 8'h04, 1'b0);
    check("wd_regrant idx", idx8, 3'd2);

    // done on the timeout cycle is a normal release
    for (int i = 0; i < 15; i++) begin
      step();
      chk8($sformatf("co_hold%0d", i), 8'h04, 1'b0);
    end
    done8 = 1'b1;
    step();
    chk8("co_release", 8'h00, 1'b0);
    done8 = 1'b0;
    step();
    chk8("co_regrant", 8'h04, 1'b0);
    req8  = 8'h00;
    done8 = 1'b1;
    step();
    chk8("co_final", 8'h00, 1'b0);
    done8 = 1'b0;

    // five-input instance rotation
    req5 = 5'h1F;
    for (int g = 0; g < 6; g++) begin
      logic [4:0] eg5;
      eg5 = '0;
      eg5[g % 5] = 1'b1;
      done5 = 1'b0;
      step();
      check($sformatf("n5 grant%0d", g), gnt5, eg5);
      check($sformatf("n5 idx%0d", g), idx5, g % 5);
      done5 = 1'b1;
      step();
      check($sformatf("n5 bubble%0d", g), v5, 1'b0);
    end
    req5  = '0;
    done5 = 1'b0;

    // random traffic against the reference model
    rst_n = 1'b0;
    req8  = '0;
    done8 = 1'b0;
    model_step(req8, done8, rst_n);
    step();
    for (int i = 0; i < 600; i++) begin
      logic [7:0] eg;
      if ($urandom_range(0, 7) == 0) req8 = 8'($urandom);
      done8 = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      model_step(req8, done8, rst_n);
      step();
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      chk8($sformatf("rnd%0d", i), eg, m_terr);
      check($sformatf("rnd%0d idx", i), idx8, m_idx);
      check($sformatf("rnd%0d any", i), any8, |req8);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
